mem_wait_unit: RTL and testbench
================================

# mem_wait_unit

Unified instruction/data memory for the multicycle datapath. It accepts one read or write per access from the control FSM, inserts a parameterised number of wait states, and drives MRD, which the downstream data register samples every cycle. A one-cycle MRDY pulse lets the control FSM know when to advance from its memory state.

## Interface
- DEPTH, 256: memory size in 32-bit words; power of two, at least 4.
- WAIT, 2: wait cycles between request acceptance and completion; 0 to 15.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset, synchronous, active-low.
- MemRead  in  1  read request, level-sampled in IDLE.
- MemWrite  in  1  write request, level-sampled in IDLE.
- Addr  in  32  byte address.
- WD  in  32  write data.
- MRD  out  32  read data; holds the last completed read.
- MRDY  out  1  one-cycle completion pulse.
- BUSY  out  1  high in WAIT and DONE.
- MERR  out  1  misalignment pulse; present only with MEM_ALIGN_CHECK_EN.

## Operation
- **State machine:** IDLE, WAIT, DONE.
- **IDLE:**
  - If MemRead or MemWrite is high, latch Addr, WD and the op, and load the counter with WAIT.
  - Go to WAIT if WAIT>0, else to DONE.
- **Simultaneous MemRead and MemWrite:** the write wins and the read is dropped.
- **WAIT:** the counter decrements each cycle. When it equals 1, go to DONE.
- **DONE:**
  - Read: MRD <= mem[idx]. Write: mem[idx] <= latched WD.
  - MRDY is high for this one cycle.
  - The next state is always IDLE.
- **Word index:** idx = Addr[log2(DEPTH)+1:2]. Upper bits are ignored, so out-of-range addresses alias (wrap).
- **Requests outside IDLE:** ignored, not queued. A request still held in the IDLE cycle after DONE starts a new access.
- **Writes:** never change MRD.
- **Reset values:**
  - State IDLE, counter 0, MRD 32'h0, MRDY 0, BUSY 0, MERR 0.
  - Memory contents are not cleared by reset.
- **Reset mid-access:** the access is aborted. A pending write is not performed and MRD is not updated.

## Timing
- A request is sampled at edge 0.
- MRDY and the updated MRD are visible after edge WAIT+1 and stay so for exactly one cycle.
- BUSY is high for WAIT+1 cycles per access.
- The earliest next acceptance is at edge WAIT+2. Back-to-back throughput is one access per WAIT+2 cycles.
- MRD is stable from the DONE cycle until the next read completes, so the downstream register can capture it in any later cycle.
- A write is visible to a read accepted on any later edge.

## Configuration
- **MEM_ALIGN_CHECK_EN defined:**
  - The MERR port exists.
  - Addr[1:0] != 0 at acceptance marks the access as faulted. It still runs through WAIT and DONE with normal timing.
  - In DONE, MERR pulses together with MRDY. No memory write occurs and MRD is unchanged.
- **Not defined:** Addr[1:0] is ignored, MERR is absent, and no fault logic is present.

## Structure
- **Shared package mem_pkg:**
  - 2-bit state encodings: IDLE=0, WAIT=1, DONE=2.
  - Default DEPTH and WAIT.
  - Counter width constant: 4.
- **Sub-module mem_array:** single-port synchronous RAM (we, idx, wdata, rdata). The top holds the FSM, counter, latches and MRD register.

## Test plan
- **Write then read:** WAIT=2. Write 32'hDEADBEEF to 0x10, then read 0x10.
  - Each access gives MRDY 3 cycles after acceptance and BUSY for 3 cycles.
  - MRD=32'hDEADBEEF and holds through 5 idle cycles.
- **Wrap-around:** DEPTH=256. Write 32'h12345678 to 0x400, then read 0x000 → MRD=32'h12345678.
- **Busy collision:** start a read of 0x10. Pulse MemWrite to 0x20 with WD 32'h5 during WAIT.
  - Exactly one MRDY.
  - A later read of 0x20 returns the prior contents.
- **Simultaneous request:** MemRead and MemWrite both high, Addr 0x8, WD 32'hA5A5A5A5.
  - The write is performed and MRD is unchanged.
  - A later read of 0x8 returns 32'hA5A5A5A5.
- **Reset mid-write:** assert RST_N=0 during WAIT of a write of 32'hFFFFFFFF to 0x4.
  - All outputs read 0 after the reset edge.
  - A later read of 0x4 returns the old value.
- **WAIT=0 and misalignment (MEM_ALIGN_CHECK_EN):** with WAIT=0, read 0x11.
  - MRDY and MERR pulse one cycle after acceptance and MRD is unchanged.
  - A read of 0x10 gives MERR=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory: state encodings, defaults and counter width.
package mem_pkg;

    localparam int DEFAULT_DEPTH = 256;
    localparam int DEFAULT_WAIT  = 2;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: write on we, registered read of idx every cycle.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately left out of reset so they survive RST_N.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_wait_unit.sv
// Unified instruction/data memory with WAIT wait states and a one-cycle MRDY completion pulse.
// Define MEM_ALIGN_CHECK_EN to add the misaligned-access fault path and the MERR port.
module mem_wait_unit
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WAIT  = DEFAULT_WAIT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] MRD,
    output logic        MRDY,
    output logic        BUSY,
    output logic [1:0]  dbg_state
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        MERR
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [AW-1:0]    idx_q, ram_idx;
    logic [31:0]      wd_q, ram_rdata;
    logic             wr_q, accept, fault, ram_we;
    logic             unused_addr;

    // Handshake: MemRead/MemWrite are levels sampled only while IDLE (requests seen
    // while BUSY are dropped, never queued); MRDY is a one-cycle done pulse per access.
    assign accept      = (state == S_IDLE) && (MemRead || MemWrite);
    assign BUSY        = (state != S_IDLE);
    assign dbg_state   = state;
    assign unused_addr = ^{Addr[31:AW+2], Addr[1:0]};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx_q <= '0;
            wd_q  <= '0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q <= Addr[AW+1:2];
                wd_q  <= WD;
                wr_q  <= MemWrite;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    cnt_nxt   = WAIT_CNT;
                    state_nxt = (WAIT_CNT == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // While IDLE the RAM reads the incoming address so data is ready even with WAIT=0.
    assign ram_idx = (state == S_IDLE) ? Addr[AW+1:2] : idx_q;
    assign ram_we  = (state == S_DONE) && wr_q && !fault && RST_N;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK   (CLK),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wd_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            MRD  <= '0;
            MRDY <= 1'b0;
        end else begin
            MRDY <= (state == S_DONE);
            if ((state == S_DONE) && !wr_q && !fault) begin
                MRD <= ram_rdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fault_q <= 1'b0;
            MERR    <= 1'b0;
        end else begin
            if (accept) begin
                fault_q <= |Addr[1:0];
            end
            MERR <= (state == S_DONE) && fault_q;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wait_unit.sv
// Bench for mem_wait_unit: one instance with WAIT=2, one with WAIT=0, random accesses
// checked against an array-based memory model and per-access timing expectations.
module tb_mem_wait_unit;

    localparam int DEPTH = 256;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n     = 2'b00;
    logic [1:0]       mem_read  = 2'b00;
    logic [1:0]       mem_write = 2'b00;
    logic [1:0][31:0] addr      = '0;
    logic [1:0][31:0] wd        = '0;
    logic [1:0][31:0] mrd;
    logic [1:0]       mrdy, busy;
    logic [1:0][1:0]  dbg;
`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0]       merr;
`endif

    mem_wait_unit #(.DEPTH(DEPTH), .WAIT(2)) u_dut_a (
        .CLK       (clk),
        .RST_N     (rst_n[0]),
        .MemRead   (mem_read[0]),
        .MemWrite  (mem_write[0]),
        .Addr      (addr[0]),
        .WD        (wd[0]),
        .MRD       (mrd[0]),
        .MRDY      (mrdy[0]),
        .BUSY      (busy[0]),
        .dbg_state (dbg[0])
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .MERR      (merr[0])
`endif
    );

    mem_wait_unit #(.DEPTH(DEPTH), .WAIT(0)) u_dut_b (
        .CLK       (clk),
        .RST_N     (rst_n[1]),
        .MemRead   (mem_read[1]),
        .MemWrite  (mem_write[1]),
        .Addr      (addr[1]),
        .WD        (wd[1]),
        .MRD       (mrd[1]),
        .MRDY      (mrdy[1]),
        .BUSY      (busy[1]),
        .dbg_state (dbg[1])
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .MERR      (merr[1])
`endif
    );

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [2][DEPTH];
    logic [31:0] ref_mrd [2];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input bit s);
        return s ? 0 : 2;
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic clear_inputs(input bit s);
        mem_read[s]  = 1'b0;
        mem_write[s] = 1'b0;
        addr[s]      = '0;
        wd[s]        = '0;
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic access(input bit s, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit noise, input logic [31:0] na, input logic [31:0] nd);
        int w;
        bit flt;
        int ix;
        logic [31:0] e;
        w   = wait_of(s);
        flt = ALIGN_EN && (a[1:0] != 2'b00);
        ix  = ref_idx(a);
        if (wr) begin
            if (!flt) ref_mem[s][ix] = d;
        end else if (rd && !flt) begin
            ref_mrd[s] = ref_mem[s][ix];
        end
        exp_q.push_back(ref_mrd[s]);

        mem_read[s]  = rd;
        mem_write[s] = wr;
        addr[s]      = a;
        wd[s]        = d;
        @(posedge clk);
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            if (noise) begin
                mem_read[s]  = 1'($urandom_range(0, 1));
                mem_write[s] = 1'b1;
                addr[s]      = na;
                wd[s]        = nd;
            end else begin
                clear_inputs(s);
            end
            check("busy_during", {31'b0, busy[s]}, 32'd1);
            check("mrdy_early", {31'b0, mrdy[s]}, 32'd0);
        end
        @(negedge clk);
        clear_inputs(s);
        e = exp_q.pop_front();
        check("mrdy_done", {31'b0, mrdy[s]}, 32'd1);
        check("busy_done", {31'b0, busy[s]}, 32'd0);
        check("mrd_done", mrd[s], e);
`ifdef MEM_ALIGN_CHECK_EN
        check("merr_done", {31'b0, merr[s]}, {31'b0, flt});
`endif
    endtask

    task automatic idle(input bit s, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_mrdy", {31'b0, mrdy[s]}, 32'd0);
            check("idle_busy", {31'b0, busy[s]}, 32'd0);
            check("idle_mrd", mrd[s], ref_mrd[s]);
            check("idle_state", {30'b0, dbg[s]}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
            check("idle_merr", {31'b0, merr[s]}, 32'd0);
`endif
        end
    endtask

    // Reset asserted after edge 'at' (0..WAIT) of an access, so it lands on or before the DONE edge.
    task automatic abort(input bit s, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input int at);
        mem_read[s]  = rd;
        mem_write[s] = wr;
        addr[s]      = a;
        wd[s]        = d;
        @(posedge clk);
        @(negedge clk);
        clear_inputs(s);
        repeat (at) @(negedge clk);
        rst_n[s] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ref_mrd[s] = '0;
        check("rst_mrd", mrd[s], 32'h0);
        check("rst_mrdy", {31'b0, mrdy[s]}, 32'd0);
        check("rst_busy", {31'b0, busy[s]}, 32'd0);
        check("rst_state", {30'b0, dbg[s]}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("rst_merr", {31'b0, merr[s]}, 32'd0);
`endif
        rst_n[s] = 1'b1;
    endtask

    task automatic random_phase(input bit s, input int n);
        int          kind;
        bit          rd, wr;
        logic [31:0] a, d;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d = $urandom;
            if (kind == 0)      abort(s, rd, wr, a, d, $urandom_range(0, wait_of(s)));
            else if (kind == 1) idle(s, $urandom_range(1, 3));
            else                access(s, rd, wr, a, d, kind >= 7, $urandom, $urandom);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] prior;
        logic [31:0] keep;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            ref_mrd[s] = '0;
            check("reset_mrd", mrd[s], 32'h0);
            check("reset_mrdy", {31'b0, mrdy[s]}, 32'd0);
            check("reset_busy", {31'b0, busy[s]}, 32'd0);
            check("reset_state", {30'b0, dbg[s]}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
            check("reset_merr", {31'b0, merr[s]}, 32'd0);
`endif
        end
        rst_n = 2'b11;
        @(negedge clk);

        // Give every word a known value so any later read is defined.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                access(1'(s), 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, '0, '0);

        // Write then read, then hold through idle cycles.
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, '0, '0);
        access(1'b0, 1'b1, 1'b0, 32'h10, '0, 1'b0, '0, '0);
        check("wr_rd_lit", ref_mrd[0], 32'hDEADBEEF);
        idle(1'b0, 5);

        // Address wrap-around.
        access(1'b0, 1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0, '0, '0);
        access(1'b0, 1'b1, 1'b0, 32'h000, '0, 1'b0, '0, '0);
        check("wrap_lit", mrd[0], 32'h12345678);

        // Write pulsed while busy is dropped.
        prior = ref_mem[0][8];
        access(1'b0, 1'b1, 1'b0, 32'h10, '0, 1'b1, 32'h20, 32'h5);
        check("collide_rd", mrd[0], 32'hDEADBEEF);
        idle(1'b0, 2);
        access(1'b0, 1'b1, 1'b0, 32'h20, '0, 1'b0, '0, '0);
        check("collide_prior", mrd[0], prior);

        // Simultaneous read and write: write wins, MRD untouched.
        keep = ref_mrd[0];
        access(1'b0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, '0, '0);
        check("simul_keep", mrd[0], keep);
        access(1'b0, 1'b1, 1'b0, 32'h8, '0, 1'b0, '0, '0);
        check("simul_rd", mrd[0], 32'hA5A5A5A5);

        // Reset during the wait of a write.
        prior = ref_mem[0][1];
        abort(1'b0, 1'b0, 1'b1, 32'h4, 32'hFFFFFFFF, 1);
        idle(1'b0, 1);
        access(1'b0, 1'b1, 1'b0, 32'h4, '0, 1'b0, '0, '0);
        check("abort_old", mrd[0], prior);

        // WAIT=0 instance: single-cycle latency, misaligned then aligned read.
        access(1'b1, 1'b1, 1'b0, 32'h0, '0, 1'b0, '0, '0);
        access(1'b1, 1'b1, 1'b0, 32'h11, '0, 1'b0, '0, '0);
        idle(1'b1, 2);
        access(1'b1, 1'b1, 1'b0, 32'h10, '0, 1'b0, '0, '0);
        check("w0_aligned", mrd[1], ref_mem[1][4]);

        random_phase(1'b0, 150);
        random_phase(1'b1, 150);
        idle(1'b0, 2);
        idle(1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
